// File: rtl/serial_rx_controller_if.sv
// Host-side command and output-FIFO signals of serial_rx_controller.
// The master is the host; the slave is the controller.
interface serial_rx_controller_if #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 4
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_func;
  logic [3:0]        cfg_m;
  logic [CNT_W-1:0]  cfg_count;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output cfg_valid, cfg_func, cfg_m, cfg_count, out_ready,
    input  cfg_ready, out_data, out_valid
  );

  modport slave (
    input  cfg_valid, cfg_func, cfg_m, cfg_count, out_ready,
    output cfg_ready, out_data, out_valid
  );
endinterface

// File: rtl/serial_rx_controller.sv
// Session controller for serial_receiver: arms the receiver, collects a
// counted number of words into an output FIFO and reports session status.
module serial_rx_controller #(
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset,
  serial_rx_controller_if.slave host,
  input  logic                abort,
  output logic                rx_reset,
  output logic                rx_enable,
  output logic [1:0]          rx_func,
  output logic [3:0]          rx_m,
  input  logic [WORD_W-1:0]   rx_word,
  input  logic                rx_word_ready,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                timeout
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [TMR_W-1:0]  idle_timer;
  logic              rdy_q;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;

  logic accept, take, pop, push, last_word, timer_hit;

  assign accept    = host.cfg_valid & host.cfg_ready;
  // Words are taken on the 0->1 transition of the strobe only.
  assign take      = (state == RUN) & rx_word_ready & ~rdy_q;
  assign pop       = host.out_valid & host.out_ready;
  assign push      = take & ((occ != OCC_W'(FIFO_DEPTH)) | pop);
  assign last_word = take & (remaining == CNT_W'(1));
  assign timer_hit = (idle_timer == TMR_W'(TIMEOUT));

  assign host.out_valid = (occ != '0);
  assign host.out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    host.cfg_ready = 1'b0;
    rx_reset       = 1'b0;
    rx_enable      = 1'b0;
    done           = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        host.cfg_ready = 1'b1;
        if (accept) state_nxt = (host.cfg_count == '0) ? DONE : ARM;
      end
      ARM: begin
        rx_reset  = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        rx_enable = 1'b1;
        if (abort || last_word || timer_hit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_func    <= '0;
      rx_m       <= '0;
      remaining  <= '0;
      idle_timer <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q <= rx_word_ready;
      case (state)
        IDLE: begin
          if (accept) begin
            rx_func   <= host.cfg_func;
            rx_m      <= host.cfg_m;
            remaining <= host.cfg_count;
          end
        end
        ARM: begin
          overflow   <= 1'b0;
          timeout    <= 1'b0;
          idle_timer <= '0;
        end
        RUN: begin
          if (take) begin
            remaining  <= remaining - CNT_W'(1);
            idle_timer <= '0;
            if (!push) overflow <= 1'b1;
          end else if (!timer_hit) begin
            idle_timer <= idle_timer + TMR_W'(1);
          end
          // Timeout is flagged only when it is the reason the session ends.
          if (!abort && !last_word && timer_hit) timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rx_word;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: ;
      endcase
    end
  end

endmodule
